// File: rtl/vga_timing_pkg.sv
// Timing constants for the 640x480@60 Hz VGA path on a 100 MHz board clock.
package vga_timing_pkg;

    localparam int CLK_DIV   = 4;
    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // Coordinates are 10 bits wide, so totals above 1024 cannot be represented.
    localparam int COORD_W = 10;

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the board clock down to a one-clock pixel enable every CLK_DIV clocks.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pixel_tick
);

    localparam int              CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // Free-running modulo counter; the tick is registered so it fires the cycle after the count tops out.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            pixel_tick <= 1'b0;
        end else begin
            pixel_tick <= (div_cnt == CNT_MAX);
            if (div_cnt == CNT_MAX) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters plus registered sync, blanking and frame decodes.
module vga_sync_gen
    import vga_timing_pkg::COORD_W;
#(
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pixel_tick,
    output logic               h_sync,
    output logic               v_sync,
    output logic               video_on,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_start
);

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [COORD_W-1:0] X_VIS    = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] Y_VIS    = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic               frame_wrap;

    pixel_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_div (
        .clk       (clk),
        .reset     (reset),
        .pixel_tick(pixel_tick)
    );

    // Next raster position: step x on each pixel tick, step y when x wraps, flag the full-frame wrap.
    always_comb begin
        x_next     = pixel_x;
        y_next     = pixel_y;
        frame_wrap = 1'b0;
        if (pixel_tick) begin
            if (pixel_x == X_LAST) begin
                x_next = '0;
                if (pixel_y == Y_LAST) begin
                    y_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_next = pixel_y + COORD_W'(1);
                end
            end else begin
                x_next = pixel_x + COORD_W'(1);
            end
        end
    end

    // Counters and decodes share one register stage, with decodes taken from the next position so nothing skews.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            h_sync      <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
            v_sync      <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
            video_on    <= (x_next < X_VIS) && (y_next < Y_VIS);
            frame_start <= frame_wrap;
        end
    end

endmodule
